// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bundle of the write, clear and read signals of regfile_mp.
//
// Parameters: WIDTH (bits per entry), DEPTH (entries), AW (address width).
// Signals:
//   clear            synchronous flash-clear request
//   we0/we1          write enables, port 0 / port 1
//   waddr0/waddr1    write addresses
//   wdata0/wdata1    write data
//   wmask0/wmask1    per-bit write masks (1 = bit written)
//   raddr_a/raddr_b  read addresses
//   rdata_a/rdata_b  read data (from the register file)
//   conflict         registered overlapping-dual-write flag (from the register file)
// Modports: master drives requests and observes results; slave is the register file.
interface regfile_mp_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic             clear;
    logic             we0;
    logic             we1;
    logic [AW-1:0]    waddr0;
    logic [AW-1:0]    waddr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [WIDTH-1:0] wmask0;
    logic [WIDTH-1:0] wmask1;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             conflict;

    modport master (
        output clear, we0, we1, waddr0, waddr1, wdata0, wdata1, wmask0, wmask1,
        output raddr_a, raddr_b,
        input  rdata_a, rdata_b, conflict
    );

    modport slave (
        input  clear, we0, we1, waddr0, waddr1, wdata0, wdata1, wmask0, wmask1,
        input  raddr_a, raddr_b,
        output rdata_a, rdata_b, conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- DEPTH x WIDTH flop-based register file with two bit-masked
// write ports, two combinational read ports, flash clear and a registered
// write-conflict flag.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high; zeroes all entries and conflict
//   bus    regfile_mp_if.slave (write ports, clear, read ports, conflict)
//
// Behaviour:
//   - Port 1 wins on bits written by both ports to the same entry; bits in
//     only one mask take that port's data.
//   - Out-of-range write addresses are ignored; out-of-range reads give 0.
//   - conflict is high for one cycle after an edge where both ports wrote
//     overlapping bits of the same in-range entry (not under clear/reset).
//
// Configuration macro: REGFILE_MP_BYPASS_EN
//   defined   -> reads return the value the entry will hold after the
//                current edge (0 while clear or reset is high)
//   undefined -> reads return stored values only (pre-edge value)
module regfile_mp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    regfile_mp_if.slave bus
);

    logic [WIDTH-1:0] mem_reg    [DEPTH];
    logic [WIDTH-1:0] entry_next [DEPTH];
    logic [WIDTH-1:0] read_src   [DEPTH];
    logic [DEPTH-1:0] overlap;
    logic             conflict_reg;
    logic             conflict_next;

    // Per-entry write decode. Masks are gated by an address match against the
    // entry index, so an out-of-range address matches nothing and contributes
    // neither a write nor a conflict.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] m0;
            logic [WIDTH-1:0] m1;

            assign m0 = (bus.we0 && (bus.waddr0 == AW'(gi))) ? bus.wmask0 : '0;
            assign m1 = (bus.we1 && (bus.waddr1 == AW'(gi))) ? bus.wmask1 : '0;

            // Bits untouched hold; port-0-only bits take wdata0; any bit in
            // port 1's mask takes wdata1 (port 1 wins on overlap).
            assign entry_next[gi] = (mem_reg[gi] & ~(m0 | m1))
                                  | (bus.wdata0 & m0 & ~m1)
                                  | (bus.wdata1 & m1);

            assign overlap[gi] = |(m0 & m1);

`ifdef REGFILE_MP_BYPASS_EN
            assign read_src[gi] = (reset || bus.clear) ? '0 : entry_next[gi];
`else
            assign read_src[gi] = mem_reg[gi];
`endif
        end
    endgenerate

    assign conflict_next = |overlap;

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            conflict_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= entry_next[i];
            end
            conflict_reg <= conflict_next;
        end
    end

    // Range check on the full address so non-power-of-two DEPTH reads of
    // unused codes return zero instead of indexing past the array.
    assign bus.rdata_a  = (32'(bus.raddr_a) < DEPTH) ? read_src[bus.raddr_a] : '0;
    assign bus.rdata_b  = (32'(bus.raddr_b) < DEPTH) ? read_src[bus.raddr_b] : '0;
    assign bus.conflict = conflict_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp.
// Instantiates a default (WIDTH=8, DEPTH=4) register file and a DEPTH=5
// instance for out-of-range address checks. Inputs change on the falling
// edge; outputs are sampled away from the rising edge.
module tb_regfile_mp;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_mp_if #(.WIDTH(8), .DEPTH(4), .AW(2)) bus  ();
    regfile_mp_if #(.WIDTH(8), .DEPTH(5), .AW(3)) bus5 ();

    regfile_mp #(.WIDTH(8), .DEPTH(4), .AW(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regfile_mp #(.WIDTH(8), .DEPTH(5), .AW(3)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        $display("check %-14s observed %02h expected %02h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.we0   = 1'b0;
        bus.we1   = 1'b0;
        bus.clear = 1'b0;
        bus5.we0  = 1'b0;
        bus5.we1  = 1'b0;
        bus5.clear = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_byp;
        checks = 0;
        errors = 0;

        bus.clear = 0; bus.we0 = 0; bus.we1 = 0;
        bus.waddr0 = 0; bus.waddr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.wmask0 = 0; bus.wmask1 = 0; bus.raddr_a = 0; bus.raddr_b = 0;
        bus5.clear = 0; bus5.we0 = 0; bus5.we1 = 0;
        bus5.waddr0 = 0; bus5.waddr1 = 0; bus5.wdata0 = 0; bus5.wdata1 = 0;
        bus5.wmask0 = 0; bus5.wmask1 = 0; bus5.raddr_a = 0; bus5.raddr_b = 0;

        // Reset, then every entry reads zero on both ports.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            bus.raddr_a = 2'(i);
            bus.raddr_b = 2'(i);
            #1;
            chk($sformatf("rst_a%0d", i), bus.rdata_a, 8'h00);
            chk($sformatf("rst_b%0d", i), bus.rdata_b, 8'h00);
        end
        chk("rst_conflict", {7'b0, bus.conflict}, 8'h00);

        // Full write of A5 to entry 2, then masked write of 3C under 0F -> AC.
        @(negedge clk);
        bus.we0 = 1; bus.waddr0 = 2; bus.wdata0 = 8'hA5; bus.wmask0 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.raddr_a = 2; bus.raddr_b = 2;
        #1;
        chk("wr_full_a", bus.rdata_a, 8'hA5);
        chk("wr_full_b", bus.rdata_b, 8'hA5);
        bus.we0 = 1; bus.waddr0 = 2; bus.wdata0 = 8'h3C; bus.wmask0 = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("wr_masked", bus.rdata_a, 8'hAC);
        chk("single_noconf", {7'b0, bus.conflict}, 8'h00);

        // Overlapping dual write to entry 1: result C0, conflict for one cycle.
        bus.we0 = 1; bus.waddr0 = 1; bus.wdata0 = 8'hFF; bus.wmask0 = 8'hF0;
        bus.we1 = 1; bus.waddr1 = 1; bus.wdata1 = 8'h00; bus.wmask1 = 8'h3C;
        @(posedge clk);
        #1;
        chk("dual_conflict", {7'b0, bus.conflict}, 8'h01);
        @(negedge clk);
        idle();
        bus.raddr_a = 1;
        #1;
        chk("dual_merge", bus.rdata_a, 8'hC0);
        @(posedge clk);
        #1;
        chk("conflict_drop", {7'b0, bus.conflict}, 8'h00);

        // Same address, disjoint masks: merged value, no conflict.
        @(negedge clk);
        bus.we0 = 1; bus.waddr0 = 3; bus.wdata0 = 8'h0F; bus.wmask0 = 8'h0F;
        bus.we1 = 1; bus.waddr1 = 3; bus.wdata1 = 8'hF0; bus.wmask1 = 8'hF0;
        @(posedge clk);
        #1;
        chk("disjoint_noconf", {7'b0, bus.conflict}, 8'h00);
        @(negedge clk);
        idle();
        bus.raddr_b = 3;
        #1;
        chk("disjoint_merge", bus.rdata_b, 8'hFF);

        // Clear overrides simultaneous overlapping writes; conflict stays 0.
        bus.we0 = 1; bus.waddr0 = 0; bus.wdata0 = 8'h11; bus.wmask0 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.we0 = 1; bus.waddr0 = 3; bus.wdata0 = 8'h44; bus.wmask0 = 8'hFF;
        bus.we1 = 1; bus.waddr1 = 3; bus.wdata1 = 8'h77; bus.wmask1 = 8'hFF;
        bus.clear = 1;
        @(posedge clk);
        #1;
        chk("clear_conflict", {7'b0, bus.conflict}, 8'h00);
        @(negedge clk);
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.raddr_a = 2'(i);
            #1;
            chk($sformatf("clear_e%0d", i), bus.rdata_a, 8'h00);
        end

        // Read of an entry being written this cycle: bypass vs. stored value.
        bus.we0 = 1; bus.waddr0 = 0; bus.wdata0 = 8'h11; bus.wmask0 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.raddr_a = 0;
        #1;
        chk("e0_loaded", bus.rdata_a, 8'h11);
        bus.we0 = 1; bus.waddr0 = 0; bus.wdata0 = 8'h22; bus.wmask0 = 8'hFF;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_byp = 8'h22;
`else
        exp_byp = 8'h11;
`endif
        chk("rd_during_wr", bus.rdata_a, exp_byp);
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("e0_after_wr", bus.rdata_a, 8'h22);

        // Reset during an overlapping write: write discarded, conflict 0.
        bus.we0 = 1; bus.waddr0 = 1; bus.wdata0 = 8'h5A; bus.wmask0 = 8'hFF;
        bus.we1 = 1; bus.waddr1 = 1; bus.wdata1 = 8'hA5; bus.wmask1 = 8'h0F;
        reset = 1;
        @(posedge clk);
        #1;
        chk("rstw_conflict", {7'b0, bus.conflict}, 8'h00);
        @(negedge clk);
        reset = 0;
        idle();
        bus.raddr_a = 1; bus.raddr_b = 0;
        #1;
        chk("rstw_e1", bus.rdata_a, 8'h00);
        chk("rstw_e0", bus.rdata_b, 8'h00);

        // DEPTH=5: write to address 7 is ignored; address 4 is a real entry.
        bus5.we0 = 1; bus5.waddr0 = 7; bus5.wdata0 = 8'h55; bus5.wmask0 = 8'hFF;
        bus5.we1 = 1; bus5.waddr1 = 7; bus5.wdata1 = 8'h66; bus5.wmask1 = 8'hFF;
        @(posedge clk);
        #1;
        chk("d5_oor_noconf", {7'b0, bus5.conflict}, 8'h00);
        @(negedge clk);
        idle();
        for (int i = 0; i < 5; i++) begin
            bus5.raddr_a = 3'(i);
            #1;
            chk($sformatf("d5_e%0d", i), bus5.rdata_a, 8'h00);
        end
        bus5.raddr_a = 7;
        #1;
        chk("d5_rd7", bus5.rdata_a, 8'h00);
        bus5.we0 = 1; bus5.waddr0 = 4; bus5.wdata0 = 8'h66; bus5.wmask0 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus5.raddr_b = 4; bus5.raddr_a = 7;
        #1;
        chk("d5_e4", bus5.rdata_b, 8'h66);
        chk("d5_rd7_after", bus5.rdata_a, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
